// File: rtl/steady_state_detector.sv
// Purpose: declares the ONN settled when N consecutive per-period phase samples match; latches the pattern.
// Latency: steady_cheak/phi_out/timeout/busy are registered and change on the edge of the qualifying sample.
// Backpressure: none; phi_in is consumed only on sample_en strobes, all other cycles hold state.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   start                - pulse: begin/restart monitoring (IDLE, WATCH, STEADY, TIMEOUT)
//   sample_en, phi_in    - per-period sample strobe and oscillator phase vector
//   steady_cheak,phi_out - settled flag and frozen pattern to the phase decoder
//   timeout, busy        - network failed to settle; monitoring in progress
module steady_state_detector #(
    parameter int N_OSC           = 60,
    parameter int STABLE_CYCLES   = 16,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_en,
    input  logic [0:N_OSC-1] phi_in,
    output logic             steady_cheak,
    output logic [0:N_OSC-1] phi_out,
    output logic             timeout,
    output logic             busy
);

    localparam int MW = $clog2(STABLE_CYCLES);
    localparam int SW = $clog2(TIMEOUT_SAMPLES + 1);
    // match_cnt excludes the first sample of a run, so the last needed match is STABLE_CYCLES-2.
    localparam logic [MW-1:0] MATCH_LAST = MW'(STABLE_CYCLES - 2);
    localparam logic [SW-1:0] SAMP_LAST  = SW'(TIMEOUT_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WATCH,
        S_STEADY,
        S_TIMEOUT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [0:N_OSC-1] r_prev;
    logic [0:N_OSC-1] w_prev_nxt;
    logic             r_prev_valid;
    logic             w_prev_valid_nxt;
    logic [MW-1:0]    r_match_cnt;
    logic [MW-1:0]    w_match_nxt;
    logic [SW-1:0]    r_samp_cnt;
    logic [SW-1:0]    w_samp_nxt;
    logic [SW-1:0]    w_samp_inc;
    logic [0:N_OSC-1] r_phi_out;
    logic [0:N_OSC-1] w_phi_out_nxt;
    logic             w_same;

    assign w_samp_inc = r_samp_cnt + 1'b1;
    assign w_same     = (phi_in == r_prev);

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_prev_valid_nxt = r_prev_valid;
        w_match_nxt      = r_match_cnt;
        w_samp_nxt       = r_samp_cnt;
        w_phi_out_nxt    = r_phi_out;

        case (r_state)
            S_WATCH: begin
                if (start) begin
                    // Restart: any sample in this same cycle is discarded.
                    w_prev_valid_nxt = 1'b0;
                    w_match_nxt      = '0;
                    w_samp_nxt       = '0;
                end else if (sample_en) begin
                    w_samp_nxt = w_samp_inc;
                    if (r_prev_valid && w_same && (r_match_cnt == MATCH_LAST)) begin
                        // Settling wins over a timeout landing on the same sample.
                        w_phi_out_nxt = phi_in;
                        w_state_nxt   = S_STEADY;
                    end else begin
                        if (!r_prev_valid) begin
                            w_prev_nxt       = phi_in;
                            w_prev_valid_nxt = 1'b1;
                            w_match_nxt      = '0;
                        end else if (w_same) begin
                            w_match_nxt = r_match_cnt + 1'b1;
                        end else begin
                            w_prev_nxt  = phi_in;
                            w_match_nxt = '0;
                        end
                        if (w_samp_inc == SAMP_LAST) begin
                            w_state_nxt = S_TIMEOUT;
                        end
                    end
                end
            end
            S_IDLE, S_STEADY, S_TIMEOUT: begin
                // phi_out is deliberately left alone so the decoder keeps the last result.
                if (start) begin
                    w_state_nxt      = S_WATCH;
                    w_prev_valid_nxt = 1'b0;
                    w_match_nxt      = '0;
                    w_samp_nxt       = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_match_cnt  <= '0;
            r_samp_cnt   <= '0;
            r_phi_out    <= '0;
            steady_cheak <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_prev_valid <= w_prev_valid_nxt;
            r_match_cnt  <= w_match_nxt;
            r_samp_cnt   <= w_samp_nxt;
            r_phi_out    <= w_phi_out_nxt;
            // Flags are decoded from the next state so they are mutually exclusive by construction.
            steady_cheak <= (w_state_nxt == S_STEADY);
            timeout      <= (w_state_nxt == S_TIMEOUT);
            busy         <= (w_state_nxt == S_WATCH);
        end
    end

    assign phi_out = r_phi_out;

endmodule

// File: tb/tb_steady_state_detector.sv
module tb_steady_state_detector;

    localparam int N      = 60;
    localparam int STABLE = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sample_en;
    logic [0:N-1]  phi_in;
    logic          st_o [2];
    logic [0:N-1]  po_o [2];
    logic          to_o [2];
    logic          bz_o [2];

    always #5 clk = ~clk;

    // Instance 0: TIMEOUT_SAMPLES=32, instance 1: TIMEOUT_SAMPLES=STABLE_CYCLES=16.
    steady_state_detector #(.N_OSC(N), .STABLE_CYCLES(STABLE), .TIMEOUT_SAMPLES(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en), .phi_in(phi_in),
        .steady_cheak(st_o[0]), .phi_out(po_o[0]), .timeout(to_o[0]), .busy(bz_o[0]));

    steady_state_detector #(.N_OSC(N), .STABLE_CYCLES(STABLE), .TIMEOUT_SAMPLES(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en), .phi_in(phi_in),
        .steady_cheak(st_o[1]), .phi_out(po_o[1]), .timeout(to_o[1]), .busy(bz_o[1]));

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: per-instance history of samples taken since the last start.
    // Settled = the last STABLE samples are all identical; timed out = sample count hit the limit.
    localparam int M_IDLE = 0, M_WATCH = 1, M_STEADY = 2, M_TOUT = 3;
    int           m_mode [2];
    int           m_ns   [2];
    logic [0:N-1] m_hist [2][64];
    logic [0:N-1] m_po   [2];

    function automatic int tmo(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    task automatic model_step(input int k);
        bit eq;
        if (!rst_n) begin
            m_mode[k] = M_IDLE;
            m_ns[k]   = 0;
            m_po[k]   = '0;
        end else if (start) begin
            m_mode[k] = M_WATCH;
            m_ns[k]   = 0;
        end else if (m_mode[k] == M_WATCH && sample_en) begin
            m_hist[k][m_ns[k]] = phi_in;
            m_ns[k]++;
            eq = (m_ns[k] >= STABLE);
            if (eq)
                for (int j = m_ns[k] - STABLE; j < m_ns[k]; j++)
                    if (m_hist[k][j] != phi_in) eq = 0;
            if (eq) begin
                m_mode[k] = M_STEADY;
                m_po[k]   = phi_in;
            end else if (m_ns[k] == tmo(k)) begin
                m_mode[k] = M_TOUT;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_steady%0d", k), 64'(st_o[k]), 64'(m_mode[k] == M_STEADY));
                chk($sformatf("model_timeout%0d", k), 64'(to_o[k]), 64'(m_mode[k] == M_TOUT));
                chk($sformatf("model_busy%0d", k), 64'(bz_o[k]), 64'(m_mode[k] == M_WATCH));
                chk($sformatf("model_phi_out%0d", k), 64'(po_o[k]), 64'(m_po[k]));
            end
        end
    end

    // Drive one cycle's inputs, then return 2 time units after the active edge.
    task automatic cyc(input logic s, input logic e, input logic [0:N-1] p);
        start     = s;
        sample_en = e;
        phi_in    = p;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [0:N-1] rnd_pat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[59:0];
    endfunction

    logic [0:N-1] P1, P2, P3, noise;
    logic [0:N-1] pool [3];
    logic [0:N-1] cur;

    initial begin
        P1 = 60'hFFFF0FF0FF0FFFF;
        P2 = 60'h123456789ABCDEF;
        P3 = 60'h00F00F00F00F00F;
        pool[0] = P1; pool[1] = P2; pool[2] = P3;
        rst_n = 1'b0; start = 1'b0; sample_en = 1'b0; phi_in = '0;

        // Reset with random activity on the inputs.
        repeat (3) cyc(1'($urandom_range(1)), 1'($urandom_range(1)), rnd_pat());
        for (int k = 0; k < 2; k++) begin
            chk("rst_steady", 64'(st_o[k]), 64'd0);
            chk("rst_timeout", 64'(to_o[k]), 64'd0);
            chk("rst_busy", 64'(bz_o[k]), 64'd0);
            chk("rst_phi_out", 64'(po_o[k]), 64'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1;

        // Settle from noise: 5 random samples then a constant pattern.
        cyc(1, 0, '0);
        chk("start_busy", 64'(bz_o[0]), 64'd1);
        repeat (5) begin
            noise = rnd_pat();
            if (noise == P1) noise[0] = ~noise[0];
            cyc(0, 1, noise);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, P1);
            if (i == 11) chk("noise_b_timeout16", 64'(to_o[1]), 64'd1);
            if (i == 15) begin
                chk("noise_steady_early", 64'(st_o[0]), 64'd0);
                chk("noise_busy_early", 64'(bz_o[0]), 64'd1);
            end
        end
        chk("noise_steady", 64'(st_o[0]), 64'd1);
        chk("noise_phi_out", 64'(po_o[0]), 64'(P1));
        chk("noise_busy_fall", 64'(bz_o[0]), 64'd0);

        // Near miss: 15 same, 1 different, 16 same (the last sample is also sample 32).
        cyc(1, 0, '0);
        repeat (15) cyc(0, 1, P1);
        cyc(0, 1, P2);
        chk("nm_b_timeout", 64'(to_o[1]), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, P1);
            if (i == 15) chk("nm_no_steady", 64'(st_o[0]), 64'd0);
        end
        chk("nm_steady", 64'(st_o[0]), 64'd1);
        chk("nm_steady_beats_timeout", 64'(to_o[0]), 64'd0);

        // Timeout: alternate two patterns for 32 samples.
        cyc(1, 0, '0);
        for (int i = 1; i <= 32; i++) begin
            cyc(0, 1, (i % 2) ? P1 : P2);
            if (i == 31) chk("to_early", 64'(to_o[0]), 64'd0);
        end
        chk("to_flag", 64'(to_o[0]), 64'd1);
        chk("to_no_steady", 64'(st_o[0]), 64'd0);
        chk("to_busy", 64'(bz_o[0]), 64'd0);

        // Simultaneous steady/timeout on instance b.
        cyc(1, 0, '0);
        repeat (16) cyc(0, 1, P1);
        chk("sim_steady", 64'(st_o[1]), 64'd1);
        chk("sim_timeout", 64'(to_o[1]), 64'd0);

        // Restart from STEADY and re-settle on a new pattern.
        cyc(1, 0, '0);
        chk("rs_steady_drop", 64'(st_o[0]), 64'd0);
        chk("rs_busy", 64'(bz_o[0]), 64'd1);
        chk("rs_phi_kept", 64'(po_o[0]), 64'(P1));
        repeat (16) cyc(0, 1, P3);
        chk("rs_resettle", 64'(st_o[0]), 64'd1);
        chk("rs_phi_new", 64'(po_o[0]), 64'(P3));

        // start together with sample_en in IDLE: that sample does not count.
        rst_n = 1'b0;
        cyc(0, 0, '0);
        rst_n = 1'b1;
        cyc(1, 1, P1);
        repeat (15) cyc(0, 1, P1);
        chk("idle_start_sample_ignored", 64'(st_o[0]), 64'd0);
        cyc(0, 1, P1);
        chk("idle_start_then_steady", 64'(st_o[0]), 64'd1);

        // Reset mid-WATCH.
        cyc(1, 0, '0);
        repeat (5) cyc(0, 1, P1);
        rst_n = 1'b0;
        cyc(0, 1, P1);
        chk("abort_busy", 64'(bz_o[0]), 64'd0);
        chk("abort_phi_out", 64'(po_o[0]), 64'd0);
        chk("abort_steady", 64'(st_o[0]), 64'd0);
        rst_n = 1'b1;

        // Random traffic: sticky patterns, random strobes, restarts and rare resets.
        cur = P1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) cur = pool[$urandom_range(2)];
            rst_n = ($urandom_range(499) != 0);
            cyc(1'($urandom_range(99) == 0), 1'($urandom_range(3) != 0), cur);
        end
        rst_n = 1'b1;
        repeat (2) cyc(0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
